video_stream_arbiter: RTL and testbench
=======================================

Name: video_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one video stream processor (e.g. the YUV422-to-444 converter) between N_SRC DMA requesters.
- Sits between the per-channel read DMA streams and the converter's slave stream port.
- Grant is held for a whole packet, up to and including the t_last beat.
- Output is registered, one beat per cycle sustained within a packet.

Parameters:
- N_SRC, 4, number of requesting stream sources (2..8).
- DATA_WIDTH, 64, stream data width in bits.
- USER_WIDTH, 1, t_user width.
- DEST_WIDTH, 3, t_dest width; must be >= clog2(N_SRC) when VIDEO_STREAM_ARB_DEST_TAG_EN is defined.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- src_t_valid  in  N_SRC  per-source valid
- src_t_ready  out  N_SRC  per-source ready
- src_t_data  in  N_SRC*DATA_WIDTH  source i occupies slice i
- src_t_keep  in  N_SRC*DATA_WIDTH/8  byte keep
- src_t_last  in  N_SRC  end of packet
- src_t_user  in  N_SRC*USER_WIDTH  user sideband
- src_t_dest  in  N_SRC*DEST_WIDTH  dest sideband
- dst  master  nasti_stream_channel  arbitrated output; t_strb = t_keep, t_id = 0
- grant_idx  out  clog2(N_SRC)  currently or last granted source (debug)
- busy  out  1  high while a packet is in progress

Behaviour:
- Clock/reset: one clock, aclk; reset aresetn is asynchronous, active-low.
- Reset values: dst.t_valid=0, dst.t_last=0, src_t_ready=0, state=IDLE, grant_idx=0, last_grant=N_SRC-1 (source 0 wins first).
- States:
  - IDLE: all src_t_ready=0. If any src_t_valid is high, latch grant = first valid index scanning last_grant+1, +2, ... modulo N_SRC, then go to XFER next cycle. One arbitration bubble per packet.
  - XFER: src_t_ready[grant] = dst.t_ready || !dst.t_valid; all others 0.
- Beat accept (src_t_valid[grant] && src_t_ready[grant]): register data/keep/last/user/dest into dst, set dst.t_valid=1. Latency 1 cycle.
- Output drain: dst.t_valid clears on a dst handshake with no new accept in the same cycle. A simultaneous dst handshake and new accept keeps dst.t_valid=1 with the new beat.
- Packet end: accepted beat with t_last=1 -> last_grant<=grant, state<=IDLE. Later beats of that source wait for the next arbitration round.
- Granted source drops valid mid-packet: grant is held (no timeout), no other source is served, and dst.t_valid drops after drain.
- Back-pressure: dst.t_ready=0 with dst.t_valid=1 holds dst payload stable and src_t_ready low.
- Single-beat packet (t_last on first beat): XFER lasts exactly one accept.
- Wrap-around: last_grant=N_SRC-1 scans from 0.
- Reset mid-packet: everything returns to reset values. The partial packet is truncated; no t_last is emitted.
- busy = (state==XFER) || dst.t_valid.

Optional Feature:
- Macro VIDEO_STREAM_ARB_DEST_TAG_EN.
- Defined: dst.t_dest = zero-extended grant index, so downstream can route results back per requester; src_t_dest is ignored.
- Not defined: dst.t_dest = src_t_dest of the granted source, passed through unchanged.

Decomposition:
- Package video_stream_pkg holds:
  - arbiter state enum (ARB_IDLE, ARB_XFER);
  - function rr_next(valid, last_grant) returning the round-robin winner;
  - localparam helper for index width.
- One sub-module, video_rr_picker: purely combinational priority rotate; returns winner index and any_valid.

Test Plan:
- Single requester: src 2 sends a 3-beat packet (data 0x11,0x22,0x33, last on 3rd), dst.t_ready=1 -> dst emits the same 3 beats on consecutive cycles, 1 cycle after each accept, t_last on 0x33; grant_idx=2.
- Fairness: all 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0; exactly one idle cycle on dst between packets.
- Back-pressure: dst.t_ready=0 for 5 cycles mid-packet -> dst payload stable, src_t_ready[grant]=0; no beat lost or duplicated after release.
- Holding: source 1 granted, drops valid after beat 1 for 4 cycles while source 3 is valid -> source 3 is not granted until source 1's t_last is accepted.
- Dest tag: with the macro defined, source 3 packet with src_t_dest=5 -> dst.t_dest=3. Without the macro -> dst.t_dest=5.
- Reset mid-packet: assert aresetn=0 during beat 2 -> dst.t_valid=0 immediately; after release, source 0 is granted first.

Source files
------------

// File: rtl/video_stream_arbiter_pkg.sv
// rtl/video_stream_arbiter_pkg.sv - shared types and round-robin helper for video_stream_arbiter
package video_stream_pkg;

  // Arbiter control states
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  // Largest source count the round-robin helper is sized for
  localparam int unsigned RR_MAX_SRC = 8;

  // Index width for a source count; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // First valid source after last_grant, wrapping modulo n_src.
  // Scanning from the farthest offset down lets the nearest hit overwrite.
  // Returns last_grant unchanged when nothing is valid.
  function automatic logic [2:0] rr_next(input logic [7:0]  valid,
                                         input logic [2:0]  last_grant,
                                         input int unsigned n_src);
    logic [2:0]  win;
    int unsigned idx;
    win = last_grant;
    for (int unsigned k = RR_MAX_SRC; k >= 1; k--) begin
      if (k <= n_src) begin
        idx = (32'(last_grant) + k) % n_src;
        if (valid[idx[2:0]]) begin
          win = idx[2:0];
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/video_stream_arbiter_if.sv
// rtl/video_stream_arbiter_if.sv - nasti_stream_channel stream interface with master/slave views
interface nasti_stream_channel #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 3,
  parameter int unsigned ID_WIDTH   = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/video_stream_arbiter_picker.sv
// rtl/video_stream_arbiter_picker.sv - combinational round-robin winner picker
module video_rr_picker
  import video_stream_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_SRC-1:0] i_valid,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_valid
);

  logic [7:0] w_valid8;
  logic [2:0] w_last3;

  assign w_valid8    = 8'(i_valid);
  assign w_last3     = 3'(i_last_grant);
  assign o_winner    = IDX_W'(rr_next(w_valid8, w_last3, N_SRC));
  assign o_any_valid = |i_valid;

endmodule

// File: rtl/video_stream_arbiter.sv
// rtl/video_stream_arbiter.sv - packet-granular round-robin stream arbiter; option VIDEO_STREAM_ARB_DEST_TAG_EN
module video_stream_arbiter
  import video_stream_pkg::*;
#(
  parameter  int unsigned N_SRC      = 4,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned USER_WIDTH = 1,
  parameter  int unsigned DEST_WIDTH = 3,
  localparam int unsigned IDX_W      = idx_width(N_SRC),
  localparam int unsigned KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_SRC-1:0]             src_t_valid,
  output logic [N_SRC-1:0]             src_t_ready,
  input  logic [N_SRC*DATA_WIDTH-1:0]  src_t_data,
  input  logic [N_SRC*KEEP_W-1:0]      src_t_keep,
  input  logic [N_SRC-1:0]             src_t_last,
  input  logic [N_SRC*USER_WIDTH-1:0]  src_t_user,
  input  logic [N_SRC*DEST_WIDTH-1:0]  src_t_dest,
  nasti_stream_channel.master          dst,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         busy
);

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [IDX_W-1:0]        r_grant;
  logic [IDX_W-1:0]        r_last_grant;
  logic [IDX_W-1:0]        w_winner;
  logic                    w_any_valid;

  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [KEEP_W-1:0]       w_sel_keep;
  logic [USER_WIDTH-1:0]   w_sel_user;
  logic [DEST_WIDTH-1:0]   w_sel_dest;

  logic                    w_out_free;
  logic                    w_accept;

  logic                    r_valid;
  logic                    r_last;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [KEEP_W-1:0]       r_keep;
  logic [USER_WIDTH-1:0]   r_user;
  logic [DEST_WIDTH-1:0]   r_dest;

  video_rr_picker #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_valid      (src_t_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  // Mux the granted source's beat onto the w_sel_* wires
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_sel_user  = '0;
    w_sel_dest  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_sel_valid = src_t_valid[i];
        w_sel_last  = src_t_last[i];
        w_sel_data  = src_t_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep  = src_t_keep[i*KEEP_W +: KEEP_W];
        w_sel_user  = src_t_user[i*USER_WIDTH +: USER_WIDTH];
        w_sel_dest  = src_t_dest[i*DEST_WIDTH +: DEST_WIDTH];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle
  assign w_out_free = dst.t_ready || !r_valid;
  assign w_accept   = (r_state == ARB_XFER) && w_sel_valid && w_out_free;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: arbitrate in IDLE, stay in XFER until the last beat is taken
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: if (w_any_valid)            w_next_state = ARB_XFER;
      ARB_XFER: if (w_accept && w_sel_last) w_next_state = ARB_IDLE;
      default:                              w_next_state = ARB_IDLE;
    endcase
  end

  // Ready goes only to the granted source while a packet is in flight
  always_comb begin
    src_t_ready = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      src_t_ready[i] = (r_state == ARB_XFER) && (r_grant == IDX_W'(i)) && w_out_free;
    end
  end

  // Grant latch and round-robin pointer; last_grant starts at the top so source 0 wins first
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_SRC - 1);
    end else begin
      if ((r_state == ARB_IDLE) && w_any_valid) begin
        r_grant <= w_winner;
      end
      if (w_accept && w_sel_last) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Output beat register: load on accept, clear on drain without a refill
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_user  <= '0;
      r_dest  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_last  <= w_sel_last;
      r_data  <= w_sel_data;
      r_keep  <= w_sel_keep;
      r_user  <= w_sel_user;
`ifdef VIDEO_STREAM_ARB_DEST_TAG_EN
      r_dest  <= DEST_WIDTH'(r_grant);
`else
      r_dest  <= w_sel_dest;
`endif
    end else if (dst.t_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef VIDEO_STREAM_ARB_DEST_TAG_EN
  // Source dest is replaced by the grant tag
  logic w_unused_dest;
  assign w_unused_dest = ^w_sel_dest;
`endif

  assign dst.t_valid = r_valid;
  assign dst.t_last  = r_last;
  assign dst.t_data  = r_data;
  assign dst.t_keep  = r_keep;
  assign dst.t_strb  = r_keep;
  assign dst.t_user  = r_user;
  assign dst.t_dest  = r_dest;
  assign dst.t_id    = '0;

  assign grant_idx = r_grant;
  assign busy      = (r_state == ARB_XFER) || r_valid;

endmodule

// File: tb/tb_video_stream_arbiter.sv
// tb/tb_video_stream_arbiter.sv - directed self-checking bench for video_stream_arbiter
module tb_video_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;
  localparam int TW = 3;

  logic            aclk    = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_last  = '0;
  wire  [N-1:0]    src_ready;
  logic [N*DW-1:0] src_data  = '0;
  logic [N*KW-1:0] src_keep  = '1;
  logic [N*UW-1:0] src_user  = '0;
  logic [N*TW-1:0] src_dest  = '0;
  wire  [1:0]      grant_idx;
  wire             busy;

  nasti_stream_channel #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(TW)) dst_if ();

  video_stream_arbiter #(
    .N_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(TW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .src_t_valid (src_valid),
    .src_t_ready (src_ready),
    .src_t_data  (src_data),
    .src_t_keep  (src_keep),
    .src_t_last  (src_last),
    .src_t_user  (src_user),
    .src_t_dest  (src_dest),
    .dst         (dst_if.master),
    .grant_idx   (grant_idx),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  dest;
    int          gap;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  dest;
    logic [1:0]  gidx;
    int          cyc;
  } out_t;

  typedef struct {
    int src;
    int cyc;
  } acc_t;

  beat_t src_q[N][$];
  out_t  out_log[$];
  acc_t  acc_log[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  // Source driver: present queue heads just after each rising edge
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0 && src_q[i][0].gap == 0) begin
          src_valid[i]          = 1'b1;
          src_data[i*DW +: DW]  = src_q[i][0].data;
          src_last[i]           = src_q[i][0].last;
          src_dest[i*TW +: TW]  = src_q[i][0].dest;
        end else begin
          src_valid[i] = 1'b0;
          if (src_q[i].size() > 0) src_q[i][0].gap = src_q[i][0].gap - 1;
        end
      end
    end
  end

  // Monitor: on the falling edge record handshakes that the next rising edge completes
  initial begin
    forever begin
      @(negedge aclk);
      cyc = cyc + 1;
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          acc_t a;
          a.src = i;
          a.cyc = cyc;
          acc_log.push_back(a);
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
      end
      if (dst_if.t_valid && dst_if.t_ready) begin
        out_t o;
        o.data = dst_if.t_data;
        o.last = dst_if.t_last;
        o.dest = dst_if.t_dest;
        o.gidx = grant_idx;
        o.cyc  = cyc;
        out_log.push_back(o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic clear_logs();
    out_log.delete();
    acc_log.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);
    clear_logs();
  endtask

  task automatic push(input int s, input logic [63:0] d, input logic l, input logic [2:0] t, input int g);
    beat_t b;
    b.data = d;
    b.last = l;
    b.dest = t;
    b.gap  = g;
    src_q[s].push_back(b);
  endtask

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && out_log.size() < n; k++) tick(1);
    if (out_log.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    dst_if.t_ready = 1'b1;
    aresetn = 1'b0;
    tick(2);
    total++; if (dst_if.t_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", dst_if.t_valid); end
    total++; if (dst_if.t_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b expected 0", dst_if.t_last); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL reset_src_ready: got %b expected 0000", src_ready); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d expected 0", grant_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    aresetn = 1'b1;
    tick(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    clear_logs();
  endtask

  task automatic test_single();
    bit ok;
    logic [63:0] exp_d [3];
    exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
    clear_logs();
    push(2, 64'h11, 1'b0, 3'd0, 0);
    push(2, 64'h22, 1'b0, 3'd0, 0);
    push(2, 64'h33, 1'b1, 3'd0, 0);
    wait_out(3, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got %0d beats expected 3", out_log.size()); end
    if (ok) begin
      for (int b = 0; b < 3; b++) begin
        total++; if (out_log[b].data !== exp_d[b]) begin bad++; $display("FAIL single_data%0d: got %0h expected %0h", b, out_log[b].data, exp_d[b]); end
        total++; if (out_log[b].last !== (b == 2)) begin bad++; $display("FAIL single_last%0d: got %b expected %b", b, out_log[b].last, (b == 2)); end
        total++; if (out_log[b].gidx !== 2'd2) begin bad++; $display("FAIL single_grant%0d: got %0d expected 2", b, out_log[b].gidx); end
      end
      total++; if (out_log[2].cyc - out_log[0].cyc !== 2) begin bad++; $display("FAIL single_spacing: got %0d expected 2", out_log[2].cyc - out_log[0].cyc); end
      total++; if (acc_log[0].src !== 2) begin bad++; $display("FAIL single_accept_src: got %0d expected 2", acc_log[0].src); end
      total++; if (out_log[0].cyc - acc_log[0].cyc !== 1) begin bad++; $display("FAIL single_latency: got %0d expected 1", out_log[0].cyc - acc_log[0].cyc); end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [63:0] exp_d [10];
    exp_d[0] = 64'h00; exp_d[1] = 64'h01; exp_d[2] = 64'h10; exp_d[3] = 64'h11;
    exp_d[4] = 64'h20; exp_d[5] = 64'h21; exp_d[6] = 64'h30; exp_d[7] = 64'h31;
    exp_d[8] = 64'h02; exp_d[9] = 64'h03;
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 64'(i * 16),     1'b0, 3'd0, 0);
      push(i, 64'(i * 16 + 1), 1'b1, 3'd0, 0);
    end
    push(0, 64'h02, 1'b0, 3'd0, 0);
    push(0, 64'h03, 1'b1, 3'd0, 0);
    wait_out(10, 80, ok);
    total++; if (!ok) begin bad++; $display("FAIL fair_timeout: got %0d beats expected 10", out_log.size()); end
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        total++; if (out_log[k].data !== exp_d[k]) begin bad++; $display("FAIL fair_data%0d: got %0h expected %0h", k, out_log[k].data, exp_d[k]); end
      end
      for (int k = 1; k < 10; k++) begin
        total++; if (out_log[k].cyc - out_log[k-1].cyc !== ((k % 2 == 1) ? 1 : 2)) begin
          bad++; $display("FAIL fair_gap%0d: got %0d expected %0d", k, out_log[k].cyc - out_log[k-1].cyc, (k % 2 == 1) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    dst_if.t_ready = 1'b1;
    push(1, 64'hA0, 1'b0, 3'd0, 0);
    push(1, 64'hA1, 1'b0, 3'd0, 0);
    push(1, 64'hA2, 1'b0, 3'd0, 0);
    push(1, 64'hA3, 1'b1, 3'd0, 0);
    wait_out(1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_start_timeout: got %0d beats expected 1", out_log.size()); end
    dst_if.t_ready = 1'b0;
    #1;
    total++; if (dst_if.t_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b expected 1", dst_if.t_valid); end
    for (int k = 0; k < 5; k++) begin
      total++; if (dst_if.t_data !== 64'hA1) begin bad++; $display("FAIL bp_hold_data%0d: got %0h expected a1", k, dst_if.t_data); end
      total++; if (src_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_src_ready%0d: got %b expected 0", k, src_ready[1]); end
      tick(1);
    end
    dst_if.t_ready = 1'b1;
    wait_out(4, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got %0d beats expected 4", out_log.size()); end
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        total++; if (out_log[b].data !== 64'(8'hA0 + b)) begin bad++; $display("FAIL bp_data%0d: got %0h expected %0h", b, out_log[b].data, 8'hA0 + b); end
        total++; if (out_log[b].last !== (b == 3)) begin bad++; $display("FAIL bp_last%0d: got %b expected %b", b, out_log[b].last, (b == 3)); end
      end
    end
    tick(5);
    total++; if (out_log.size() !== 4) begin bad++; $display("FAIL bp_count: got %0d expected 4", out_log.size()); end
  endtask

  task automatic test_holding();
    bit ok;
    logic [63:0] exp_d [4];
    exp_d[0] = 64'hB0; exp_d[1] = 64'hB1; exp_d[2] = 64'hB2; exp_d[3] = 64'hC0;
    do_reset();
    push(1, 64'hB0, 1'b0, 3'd0, 0);
    push(1, 64'hB1, 1'b0, 3'd0, 4);
    push(1, 64'hB2, 1'b1, 3'd0, 0);
    push(3, 64'hC0, 1'b1, 3'd0, 0);
    wait_out(4, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL hold_timeout: got %0d beats expected 4", out_log.size()); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        total++; if (out_log[k].data !== exp_d[k]) begin bad++; $display("FAIL hold_data%0d: got %0h expected %0h", k, out_log[k].data, exp_d[k]); end
      end
      total++; if (out_log[1].cyc - out_log[0].cyc !== 5) begin bad++; $display("FAIL hold_gap: got %0d expected 5", out_log[1].cyc - out_log[0].cyc); end
      total++; if (out_log[1].gidx !== 2'd1) begin bad++; $display("FAIL hold_grant: got %0d expected 1", out_log[1].gidx); end
      total++; if (acc_log[3].src !== 3) begin bad++; $display("FAIL hold_order: got %0d expected 3", acc_log[3].src); end
    end
  endtask

  task automatic test_dest();
    bit ok;
    logic [2:0] exp_t;
`ifdef VIDEO_STREAM_ARB_DEST_TAG_EN
    exp_t = 3'd3;
`else
    exp_t = 3'd5;
`endif
    clear_logs();
    push(3, 64'h5A5A, 1'b1, 3'd5, 0);
    wait_out(1, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL dest_timeout: got %0d beats expected 1", out_log.size()); end
    if (ok) begin
      total++; if (out_log[0].dest !== exp_t) begin bad++; $display("FAIL dest_value: got %0d expected %0d", out_log[0].dest, exp_t); end
      total++; if (out_log[0].data !== 64'h5A5A) begin bad++; $display("FAIL dest_data: got %0h expected 5a5a", out_log[0].data); end
      total++; if (out_log[0].last !== 1'b1) begin bad++; $display("FAIL dest_last: got %b expected 1", out_log[0].last); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    for (int b = 0; b < 4; b++) push(2, 64'(8'hE0 + b), (b == 3), 3'd0, 0);
    wait_out(1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_timeout: got %0d beats expected 1", out_log.size()); end
    aresetn = 1'b0;
    #1;
    total++; if (dst_if.t_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b expected 0", dst_if.t_valid); end
    total++; if (dst_if.t_last !== 1'b0) begin bad++; $display("FAIL rst_mid_last: got %b expected 0", dst_if.t_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL rst_mid_ready: got %b expected 0000", src_ready); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL rst_mid_grant: got %0d expected 0", grant_idx); end
    for (int i = 0; i < N; i++) src_q[i].delete();
    tick(2);
    total++; if (out_log.size() !== 1) begin bad++; $display("FAIL rst_mid_trunc: got %0d beats expected 1", out_log.size()); end
    aresetn = 1'b1;
    tick(1);
    clear_logs();
    push(2, 64'hF2, 1'b1, 3'd0, 0);
    push(0, 64'hF0, 1'b1, 3'd0, 0);
    wait_out(2, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_after_timeout: got %0d beats expected 2", out_log.size()); end
    if (ok) begin
      total++; if (out_log[0].data !== 64'hF0) begin bad++; $display("FAIL rst_after_first: got %0h expected f0", out_log[0].data); end
      total++; if (out_log[1].data !== 64'hF2) begin bad++; $display("FAIL rst_after_second: got %0h expected f2", out_log[1].data); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_holding();
    test_dest();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
